// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM datapath.
//
// A Moore main FSM steps each instruction through fetch, decode, execute, memory and writeback.
// Condition logic holds the NZCV flags and gates every architectural write.
//
// Parameters:
//   ALUCTRL_W  ALUControl width (>= 3); bits above [2:0] are driven 0
//   EXT_DP     1 enables EOR and CMP decode; 0 treats them as undefined
//   MEM_WAIT   1 makes FETCH/MEMRD/MEMWR wait on MemReady; 0 ignores MemReady
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   Instr[19:0]                instruction bits [31:12] from the instruction register
//   ALUFlags[3:0]              {N,Z,C,V} from the ALU, same cycle
//   MemReady                   memory has completed the current access
//   PCWrite/IRWrite/RegWrite/MemWrite  architectural write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  datapath selects
//   Undef                      sticky undefined-instruction indication
module multicycle_controller #(
  parameter int unsigned ALUCTRL_W = 3,
  parameter bit          EXT_DP    = 1'b1,
  parameter bit          MEM_WAIT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Undef
);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StUndef
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q;

  // Instr holds bits [31:12], so architectural bit k sits at index k-12.
  logic [3:0] cond;
  logic [1:0] op;
  logic       ibit;
  logic [3:0] cmd;
  logic       sbit;
  logic [3:0] rd;
  logic       unused_instr;

  assign cond         = Instr[19:16];
  assign op           = Instr[15:14];
  assign ibit         = Instr[13];
  assign cmd          = Instr[12:9];
  assign sbit         = Instr[8];   // S for data-processing, L for memory
  assign rd           = Instr[3:0];
  assign unused_instr = ^Instr[7:4];

  logic mem_done;
  assign mem_done = MemReady | ~MEM_WAIT;

  // Data-processing command decode.
  logic       cmd_valid;
  logic [2:0] cmd_alu;
  logic       is_cmp;
  logic       is_arith;

  always_comb begin
    cmd_valid = 1'b0;
    cmd_alu   = 3'b000;
    is_cmp    = 1'b0;
    is_arith  = 1'b0;
    case (cmd)
      4'b0100: begin cmd_valid = 1'b1; cmd_alu = 3'b000; is_arith = 1'b1; end
      4'b0010: begin cmd_valid = 1'b1; cmd_alu = 3'b001; is_arith = 1'b1; end
      4'b0000: begin cmd_valid = 1'b1; cmd_alu = 3'b010; end
      4'b1100: begin cmd_valid = 1'b1; cmd_alu = 3'b011; end
      4'b0001: begin cmd_valid = EXT_DP; cmd_alu = 3'b100; end
      4'b1010: begin
        cmd_valid = EXT_DP;
        cmd_alu   = 3'b001;
        is_cmp    = 1'b1;
        is_arith  = 1'b1;
      end
      default: cmd_valid = 1'b0;
    endcase
  end

  // Condition evaluation against the stored flags.
  logic cond_ex;
  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = fz;
      4'b0001: cond_ex = ~fz;
      4'b0010: cond_ex = fc;
      4'b0011: cond_ex = ~fc;
      4'b0100: cond_ex = fn;
      4'b0101: cond_ex = ~fn;
      4'b0110: cond_ex = fv;
      4'b0111: cond_ex = ~fv;
      4'b1000: cond_ex = fc & ~fz;
      4'b1001: cond_ex = ~fc | fz;
      4'b1010: cond_ex = (fn == fv);
      4'b1011: cond_ex = (fn != fv);
      4'b1100: cond_ex = ~fz & (fn == fv);
      4'b1101: cond_ex = fz | (fn != fv);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flag write enables: [1] loads N,Z, [0] loads C,V.
  logic [1:0] flag_w;
  logic       in_exec;
  assign flag_w[1] = sbit | is_cmp;
  assign flag_w[0] = (is_arith & sbit) | is_cmp;
  assign in_exec   = (state_q == StExecR) || (state_q == StExecI);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_done) state_d = StDecode;
      StDecode: begin
        case (op)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = !cmd_valid ? StUndef : (ibit ? StExecI : StExecR);
          2'b10:   state_d = StBranch;
          default: state_d = StUndef;
        endcase
      end
      StMemAdr: state_d = sbit ? StMemRd : StMemWr;
      StMemRd:  if (mem_done) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_done) state_d = StFetch;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StUndef:  state_d = StUndef;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (in_exec && cond_ex && flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (in_exec && cond_ex && flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Moore outputs; raw enables are gated by condition and reset below.
  logic       fetch_exit;
  logic       reg_w;
  logic       mem_w;
  logic       pcs;
  logic [2:0] alu_sel;

  always_comb begin
    fetch_exit = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    pcs        = 1'b0;
    alu_sel    = 3'b000;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    unique case (state_q)
      StFetch: begin
        fetch_exit = mem_done;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StMemAdr: ALUSrcB = 2'b01;
      StMemRd:  AdrSrc  = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
        pcs       = (rd == 4'hF);
      end
      StMemWr: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      StExecR: alu_sel = cmd_alu;
      StExecI: begin
        ALUSrcB = 2'b01;
        alu_sel = cmd_alu;
      end
      StAluWb: begin
        reg_w = ~is_cmp;
        pcs   = (rd == 4'hF);
      end
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcs       = 1'b1;
      end
      default: ;
    endcase

    ALUControl      = '0;
    ALUControl[2:0] = alu_sel;
  end

  assign IRWrite  = fetch_exit & ~reset;
  assign PCWrite  = (fetch_exit | (pcs & cond_ex)) & ~reset;
  assign RegWrite = reg_w & cond_ex & ~reset;
  assign MemWrite = mem_w & cond_ex & ~reset;
  assign Undef    = (state_q == StUndef);

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller.
// Two instances: dut_a (ALUCTRL_W=4, EXT_DP=1, MEM_WAIT=1) and dut_b (ALUCTRL_W=3, EXT_DP=0,
// MEM_WAIT=0). Only the selected one runs; the other is held in reset.
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [19:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_ready;

  logic pcw_a, irw_a, rw_a, mw_a, adr_a, srca_a, und_a;
  logic [1:0] srcb_a, res_a, imm_a, regs_a;
  logic [3:0] aluc_a;
  logic pcw_b, irw_b, rw_b, mw_b, adr_b, srca_b, und_b;
  logic [1:0] srcb_b, res_b, imm_b, regs_b;
  logic [2:0] aluc_b;

  multicycle_controller #(.ALUCTRL_W(4), .EXT_DP(1'b1), .MEM_WAIT(1'b1)) dut_a (
    .clk(clk), .reset(rst_a), .Instr(instr), .ALUFlags(alu_flags), .MemReady(mem_ready),
    .PCWrite(pcw_a), .IRWrite(irw_a), .RegWrite(rw_a), .MemWrite(mw_a), .AdrSrc(adr_a),
    .ALUSrcA(srca_a), .ALUSrcB(srcb_a), .ResultSrc(res_a), .ImmSrc(imm_a), .RegSrc(regs_a),
    .ALUControl(aluc_a), .Undef(und_a)
  );

  multicycle_controller #(.ALUCTRL_W(3), .EXT_DP(1'b0), .MEM_WAIT(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .Instr(instr), .ALUFlags(alu_flags), .MemReady(mem_ready),
    .PCWrite(pcw_b), .IRWrite(irw_b), .RegWrite(rw_b), .MemWrite(mw_b), .AdrSrc(adr_b),
    .ALUSrcA(srca_b), .ALUSrcB(srcb_b), .ResultSrc(res_b), .ImmSrc(imm_b), .RegSrc(regs_b),
    .ALUControl(aluc_b), .Undef(und_b)
  );

  typedef struct packed {
    logic       pcw, irw, rw, mw, adr, srca;
    logic [1:0] srcb, res, imm, regs;
    logic [3:0] aluc;
    logic       undef;
  } outs_t;

  bit    sel;
  outs_t act;
  always_comb begin
    if (sel) act = {pcw_b, irw_b, rw_b, mw_b, adr_b, srca_b, srcb_b, res_b, imm_b, regs_b,
                    {1'b0, aluc_b}, und_b};
    else     act = {pcw_a, irw_a, rw_a, mw_a, adr_a, srca_a, srcb_a, res_a, imm_a, regs_a,
                    aluc_a, und_a};
  end

  outs_t exp_q[$];
  outs_t mask_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  // Monitor: compares the presented outputs each cycle an expectation is pending.
  always @(negedge clk) begin
    outs_t e, m;
    string t;
    logic [18:0] diff;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      t = tag_q.pop_front();
      diff = (act ^ e) & m;
      checks++;
      if (diff != '0) begin
        errors++;
        $display("FAIL %s instr=%h act=%h exp=%h mask=%h", t, instr, act, e, m);
      end
    end
  end

  // Reference model state.
  bit         model_ext, model_mw;
  logic [3:0] flags_m;

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] fl);
    bit n, z, cc, v, r;
    logic [2:0] base;
    {n, z, cc, v} = fl;
    base = c[3:1];
    case (base)
      3'd0: r = z;
      3'd1: r = cc;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cc && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !r : r;
  endfunction

  task automatic dp_decode(input logic [3:0] cmd, input bit ext, output bit ok,
                           output logic [2:0] code, output bit cmp, output bit arith);
    ok = 1'b1; code = 3'd0; cmp = 1'b0; arith = 1'b0;
    case (cmd)
      4'h4: begin code = 3'd0; arith = 1'b1; end
      4'h2: begin code = 3'd1; arith = 1'b1; end
      4'h0: code = 3'd2;
      4'hC: code = 3'd3;
      4'h1: begin ok = ext; code = 3'd4; end
      4'hA: begin ok = ext; code = 3'd1; cmp = 1'b1; arith = 1'b1; end
      default: ok = 1'b0;
    endcase
  endtask

  task automatic step(input outs_t e, input outs_t m, input string t, input logic rdy,
                      input logic [3:0] f, input logic rst);
    mem_ready = rdy;
    alu_flags = f;
    if (sel) begin rst_b = rst; rst_a = 1'b1; end
    else     begin rst_a = rst; rst_b = 1'b1; end
    exp_q.push_back(e);
    mask_q.push_back(m);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Write enables must stay low while reset is high, whatever state the FSM is in.
  task automatic do_reset();
    outs_t e, m;
    e = '0; m = '0;
    m.pcw = 1'b1; m.irw = 1'b1; m.rw = 1'b1; m.mw = 1'b1;
    for (int i = 0; i < 2; i++) step(e, m, "reset_writes", 1'b1, 4'($urandom), 1'b1);
    flags_m = 4'b0000;
  endtask

  task automatic hold_undef(input outs_t b, input outs_t bm);
    outs_t e;
    e = b;
    e.undef = 1'b1;
    for (int i = 0; i < 10; i++) step(e, bm, "undef_hold", 1'($urandom), 4'($urandom), 1'b0);
    do_reset();
  endtask

  // Walks one instruction; the expected output for every cycle goes to the scoreboard.
  task automatic run_instr(input logic [19:0] ins, input int wf, input int wm,
                           input logic [3:0] xf, input bit abort_mem);
    outs_t b, bm, e, m;
    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic       ibit, sl;
    bit         ce, ok, cmp, arith;
    logic [2:0] code;
    cond = ins[19:16]; op = ins[15:14]; ibit = ins[13]; cmd = ins[12:9];
    sl = ins[8]; rd = ins[3:0];
    instr = ins;

    b = '0; bm = '0;
    bm.pcw = 1'b1; bm.irw = 1'b1; bm.rw = 1'b1; bm.mw = 1'b1; bm.undef = 1'b1;
    bm.aluc = 4'h8;
    b.imm = op; bm.imm = 2'b11;
    b.regs[0] = (op == 2'b10); bm.regs[0] = 1'b1;
    if (op == 2'b00 && !ibit) begin bm.regs[1] = 1'b1; b.regs[1] = 1'b0; end
    if (op == 2'b01 && !sl)   begin bm.regs[1] = 1'b1; b.regs[1] = 1'b1; end
    ce = cond_holds(cond, flags_m);

    // Fetch
    e = b; m = bm;
    e.adr = 1'b0; m.adr = 1'b1; e.srca = 1'b1; m.srca = 1'b1;
    e.srcb = 2'b10; m.srcb = 2'b11; m.aluc = 4'hF; e.res = 2'b10; m.res = 2'b11;
    if (model_mw) for (int i = 0; i < wf; i++) step(e, m, "fetch_wait", 1'b0, 4'($urandom), 1'b0);
    e.irw = 1'b1; e.pcw = 1'b1;
    step(e, m, "fetch_exit", model_mw ? 1'b1 : 1'b0, 4'($urandom), 1'b0);

    // Decode
    e = b; m = bm;
    e.srca = 1'b1; m.srca = 1'b1; e.srcb = 2'b10; m.srcb = 2'b11;
    m.aluc = 4'hF; e.res = 2'b10; m.res = 2'b11;
    step(e, m, "decode", 1'($urandom), 4'($urandom), 1'b0);

    case (op)
      2'b00: begin
        dp_decode(cmd, model_ext, ok, code, cmp, arith);
        if (!ok) begin
          hold_undef(b, bm);
        end else begin
          e = b; m = bm;
          e.srca = 1'b0; m.srca = 1'b1; e.srcb = ibit ? 2'b01 : 2'b00; m.srcb = 2'b11;
          e.aluc = {1'b0, code}; m.aluc = 4'hF;
          step(e, m, ibit ? "exec_imm" : "exec_reg", 1'($urandom), xf, 1'b0);
          if (ce) begin
            if (sl || cmp) flags_m[3:2] = xf[3:2];
            if (cmp || (sl && arith)) flags_m[1:0] = xf[1:0];
          end
          ce = cond_holds(cond, flags_m);
          e = b; m = bm;
          e.res = 2'b00; m.res = 2'b11;
          e.rw = ce && !cmp; e.pcw = ce && (rd == 4'hF);
          step(e, m, "alu_wb", 1'($urandom), 4'($urandom), 1'b0);
        end
      end
      2'b01: begin
        e = b; m = bm;
        e.srca = 1'b0; m.srca = 1'b1; e.srcb = 2'b01; m.srcb = 2'b11; m.aluc = 4'hF;
        step(e, m, "mem_adr", 1'($urandom), 4'($urandom), 1'b0);
        e = b; m = bm;
        e.adr = 1'b1; m.adr = 1'b1;
        if (!sl) e.mw = ce;
        if (model_mw)
          for (int i = 0; i < wm; i++)
            step(e, m, sl ? "mem_rd_wait" : "mem_wr_wait", 1'b0, 4'($urandom), 1'b0);
        if (abort_mem) begin
          do_reset();
        end else begin
          step(e, m, sl ? "mem_rd" : "mem_wr", model_mw ? 1'b1 : 1'b0, 4'($urandom), 1'b0);
          if (sl) begin
            e = b; m = bm;
            e.res = 2'b01; m.res = 2'b11; e.rw = ce; e.pcw = ce && (rd == 4'hF);
            step(e, m, "mem_wb", 1'($urandom), 4'($urandom), 1'b0);
          end
        end
      end
      2'b10: begin
        e = b; m = bm;
        e.srca = 1'b0; m.srca = 1'b1; e.srcb = 2'b01; m.srcb = 2'b11; m.aluc = 4'hF;
        e.res = 2'b10; m.res = 2'b11; e.pcw = ce;
        step(e, m, "branch", 1'($urandom), 4'($urandom), 1'b0);
      end
      default: hold_undef(b, bm);
    endcase
  endtask

  function automatic logic [19:0] rand_instr();
    logic [19:0] r;
    logic [3:0]  cmds[6];
    int          k;
    cmds = '{4'h4, 4'h2, 4'h0, 4'hC, 4'h1, 4'hA};
    r = 20'($urandom);
    if ($urandom_range(0, 3) != 0) r[19:16] = 4'hE;
    k = $urandom_range(0, 19);
    if (k < 9)       r[15:14] = 2'b00;
    else if (k < 14) r[15:14] = 2'b01;
    else if (k < 19) r[15:14] = 2'b10;
    else             r[15:14] = 2'b11;
    if (r[15:14] == 2'b00 && $urandom_range(0, 7) != 0) r[12:9] = cmds[$urandom_range(0, 5)];
    return r;
  endfunction

  initial begin
    sel = 1'b0; model_ext = 1'b1; model_mw = 1'b1; flags_m = 4'b0000;
    instr = 20'h0; rst_a = 1'b1; rst_b = 1'b1; mem_ready = 1'b0; alu_flags = 4'h0;
    @(posedge clk);
    #1;

    // Full-featured configuration
    do_reset();
    run_instr(20'h0A000, 0, 0, 4'h0, 1'b0);        // BEQ after reset: flags 0000, not taken
    run_instr(20'hE0821, 0, 0, 4'($urandom), 1'b0); // ADD R1,R2,R3
    run_instr(20'hE5902, 0, 2, 4'h0, 1'b0);         // LDR with two wait cycles
    run_instr(20'hE5802, 1, 1, 4'h0, 1'b0);         // STR, MemWrite held through wait
    run_instr(20'hE1510, 0, 0, 4'b0100, 1'b0);      // CMP sets Z
    run_instr(20'h0A000, 0, 0, 4'h0, 1'b0);         // BEQ taken
    run_instr(20'hE1510, 0, 0, 4'b0000, 1'b0);      // CMP clears Z
    run_instr(20'h0A000, 0, 0, 4'h0, 1'b0);         // BEQ not taken
    run_instr(20'hE0221, 0, 0, 4'($urandom), 1'b0); // EOR
    run_instr(20'hF0821, 0, 0, 4'($urandom), 1'b0); // cond 1111: no writes
    run_instr(20'hE082F, 0, 0, 4'($urandom), 1'b0); // ADD to R15 writes PC
    run_instr(20'hEC000, 0, 0, 4'h0, 1'b0);         // op=11: undefined, then reset
    run_instr(20'hE5902, 0, 3, 4'h0, 1'b1);         // reset during MEMRD wait
    run_instr(20'hE0821, 2, 0, 4'($urandom), 1'b0);
    for (int i = 0; i < 200; i++)
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom), 1'b0);

    // Reduced configuration: no extended ops, no memory wait
    sel = 1'b1; model_ext = 1'b0; model_mw = 1'b0;
    do_reset();
    run_instr(20'hE0821, 0, 0, 4'($urandom), 1'b0); // fetch exits with MemReady=0
    run_instr(20'hE5902, 0, 0, 4'h0, 1'b0);
    run_instr(20'hE0221, 0, 0, 4'h0, 1'b0);         // EOR undefined here
    run_instr(20'hE1510, 0, 0, 4'h0, 1'b0);         // CMP undefined here
    for (int i = 0; i < 80; i++)
      run_instr(rand_instr(), 0, 0, 4'($urandom), 1'b0);

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
